// File: rtl/alu_txn_ctrl.sv
// alu_txn_ctrl: byte-stream transaction sequencer for the 8-bit combinational ALU.
// Collects operand A, operand B and opcode from the RX stream, presents them to
// the ALU for one cycle, then returns the ALU result as one byte on the TX stream.
// Optional opcode legality checking is compiled in with `define ALU_OPCODE_CHECK_EN.
module alu_txn_ctrl #(
    parameter int SIZEDATA = 8,
    parameter int SIZEOP   = 6,
    parameter int CNTW     = 16
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                CLEAR,
    input  logic [SIZEDATA-1:0] RX_DATA,
    input  logic                RX_VALID,
    output logic                RX_READY,
    output logic [SIZEDATA-1:0] TX_DATA,
    output logic                TX_VALID,
    input  logic                TX_READY,
    output logic [SIZEDATA-1:0] DATOA,
    output logic [SIZEDATA-1:0] DATOB,
    output logic [SIZEOP-1:0]   OPCODE,
    input  logic [SIZEDATA-1:0] RESULT,
    output logic                BUSY,
    output logic                ERROR,
    output logic [CNTW-1:0]     TXN_COUNT
);

    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        GET_OP = 3'd2,
        EXEC   = 3'd3,
        SEND   = 3'd4
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic                  load_a_s;
    logic                  load_b_s;
    logic                  load_op_s;
    logic                  op_err_s;
    logic                  exec_s;
    logic                  send_done_s;
    logic [SIZEDATA-1:0]   datoa_r;
    logic [SIZEDATA-1:0]   datob_r;
    logic [SIZEOP-1:0]     opcode_r;
    logic [SIZEDATA-1:0]   tx_data_r;
    logic                  tx_valid_r;
    logic [CNTW-1:0]       txn_count_r;
    logic                  error_r;

`ifdef ALU_OPCODE_CHECK_EN
    // Legal opcode byte: upper bits zero and low bits one of the supported ALU functions.
    function automatic logic opcode_legal(input logic [SIZEDATA-1:0] b);
        logic ok;
        if ((b >> SIZEOP) != {SIZEDATA{1'b0}}) begin
            ok = 1'b0;
        end else begin
            case (b[SIZEOP-1:0])
                SIZEOP'(6'h20), SIZEOP'(6'h22), SIZEOP'(6'h24), SIZEOP'(6'h25),
                SIZEOP'(6'h26), SIZEOP'(6'h27), SIZEOP'(6'h03), SIZEOP'(6'h02): ok = 1'b1;
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction
`endif

    // Ready is decoded from state only, so it reads 1 while reset holds the FSM in GET_A.
    assign RX_READY  = (state_r == GET_A) || (state_r == GET_B) || (state_r == GET_OP);
    assign BUSY      = (state_r != GET_A);
    assign DATOA     = datoa_r;
    assign DATOB     = datob_r;
    assign OPCODE    = opcode_r;
    assign TX_DATA   = tx_data_r;
    assign TX_VALID  = tx_valid_r;
    assign TXN_COUNT = txn_count_r;
    assign ERROR     = error_r;

    // Next-state and load-strobe decode; CLEAR overrides every handshake.
    always_comb begin
        state_nxt_s = state_r;
        load_a_s    = 1'b0;
        load_b_s    = 1'b0;
        load_op_s   = 1'b0;
        op_err_s    = 1'b0;
        exec_s      = 1'b0;
        send_done_s = 1'b0;
        if (CLEAR) begin
            state_nxt_s = GET_A;
        end else begin
            case (state_r)
                GET_A: begin
                    if (RX_VALID) begin
                        load_a_s    = 1'b1;
                        state_nxt_s = GET_B;
                    end else begin
                        state_nxt_s = GET_A;
                    end
                end
                GET_B: begin
                    if (RX_VALID) begin
                        load_b_s    = 1'b1;
                        state_nxt_s = GET_OP;
                    end else begin
                        state_nxt_s = GET_B;
                    end
                end
                GET_OP: begin
                    if (RX_VALID) begin
`ifdef ALU_OPCODE_CHECK_EN
                        if (opcode_legal(RX_DATA)) begin
                            load_op_s   = 1'b1;
                            state_nxt_s = EXEC;
                        end else begin
                            op_err_s    = 1'b1;
                            state_nxt_s = GET_A;
                        end
`else
                        load_op_s   = 1'b1;
                        state_nxt_s = EXEC;
`endif
                    end else begin
                        state_nxt_s = GET_OP;
                    end
                end
                EXEC: begin
                    exec_s      = 1'b1;
                    state_nxt_s = SEND;
                end
                SEND: begin
                    if (tx_valid_r && TX_READY) begin
                        send_done_s = 1'b1;
                        state_nxt_s = GET_A;
                    end else begin
                        state_nxt_s = SEND;
                    end
                end
                default: begin
                    state_nxt_s = GET_A;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r <= GET_A;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // ALU operand registers; they hold their last value between transactions.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            datoa_r  <= {SIZEDATA{1'b0}};
            datob_r  <= {SIZEDATA{1'b0}};
            opcode_r <= {SIZEOP{1'b0}};
        end else begin
            if (load_a_s) begin
                datoa_r <= RX_DATA;
            end
            if (load_b_s) begin
                datob_r <= RX_DATA;
            end
            if (load_op_s) begin
                opcode_r <= RX_DATA[SIZEOP-1:0];
            end
        end
    end

    // TX result capture at the end of EXEC; valid drops on handshake or abort.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            tx_data_r  <= {SIZEDATA{1'b0}};
            tx_valid_r <= 1'b0;
        end else if (CLEAR) begin
            tx_valid_r <= 1'b0;
        end else if (exec_s) begin
            tx_data_r  <= RESULT;
            tx_valid_r <= 1'b1;
        end else if (send_done_s) begin
            tx_valid_r <= 1'b0;
        end
    end

    // Completed-transaction counter, wraps silently.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            txn_count_r <= {CNTW{1'b0}};
        end else if (send_done_s) begin
            txn_count_r <= txn_count_r + {{(CNTW-1){1'b0}}, 1'b1};
        end
    end

    // One-cycle illegal-opcode pulse; never set when checking is compiled out.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            error_r <= 1'b0;
        end else begin
            error_r <= op_err_s;
        end
    end

endmodule

// File: tb/tb_alu_txn_ctrl.sv
// Scoreboard bench for alu_txn_ctrl with a behavioural ALU driving RESULT.
module tb_alu_txn_ctrl;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       CLEAR;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       RX_READY;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_READY;
    logic [7:0] DATOA;
    logic [7:0] DATOB;
    logic [5:0] OPCODE;
    logic [7:0] RESULT;
    logic       BUSY;
    logic       ERROR;
    logic [15:0] TXN_COUNT;

    int         vec_cnt = 0;
    int         err_cnt = 0;
    int         exp_txn = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    always #5 CLK = ~CLK;

    alu_txn_ctrl dut (
        .CLK(CLK), .RESET_N(RESET_N), .CLEAR(CLEAR),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
        .DATOA(DATOA), .DATOB(DATOB), .OPCODE(OPCODE), .RESULT(RESULT),
        .BUSY(BUSY), .ERROR(ERROR), .TXN_COUNT(TXN_COUNT)
    );

    // Behavioural stand-in for the combinational ALU.
    always_comb begin
        case (OPCODE)
            6'h20:   RESULT = DATOA + DATOB;
            6'h22:   RESULT = DATOA - DATOB;
            6'h24:   RESULT = DATOA & DATOB;
            6'h25:   RESULT = DATOA | DATOB;
            6'h26:   RESULT = DATOA ^ DATOB;
            6'h27:   RESULT = ~(DATOA | DATOB);
            6'h03:   RESULT = $signed(DATOA) >>> DATOB;
            6'h02:   RESULT = DATOA >> DATOB;
            default: RESULT = 8'h00;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on every TX handshake.
    always @(negedge CLK) begin
        if (RESET_N && TX_VALID && TX_READY && !CLEAR) begin
            if (exp_q.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL unexpected_tx: got 0x%0h expected no response", TX_DATA);
            end else begin
                mon_exp = exp_q.pop_front();
                check("tx_data", {24'h0, TX_DATA}, {24'h0, mon_exp});
            end
        end
    end

    // Offer one byte and wait (bounded) for it to be accepted; returns at posedge+1.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge CLK);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        while (!RX_READY && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!RX_READY) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL rx_timeout: got ready 0 expected ready 1");
        end
        @(posedge CLK);
        #1;
        RX_VALID = 1'b0;
    endtask

    // Wait for all expected responses, then confirm the transaction count.
    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (exp_q.size() != 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL tx_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge CLK);
        check("txn_count", {16'h0, TXN_COUNT}, exp_txn);
    endtask

    task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input logic [7:0] exp);
        exp_q.push_back(exp);
        exp_txn++;
        send_byte(a);
        send_byte(b);
        send_byte(op);
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N  = 1'b0;
        CLEAR    = 1'b0;
        RX_DATA  = 8'h00;
        RX_VALID = 1'b0;
        TX_READY = 1'b1;
        #12;
        check("rst_datoa", {24'h0, DATOA}, 32'h0);
        check("rst_opcode", {26'h0, OPCODE}, 32'h0);
        check("rst_tx_valid", {31'h0, TX_VALID}, 32'h0);
        check("rst_rx_ready", {31'h0, RX_READY}, 32'h1);
        check("rst_count", {16'h0, TXN_COUNT}, 32'h0);
        @(negedge CLK);
        RESET_N = 1'b1;

        // Test 1: ADD with latency checks.
        exp_q.push_back(8'h09);
        exp_txn++;
        send_byte(8'h07);
        send_byte(8'h02);
        send_byte(8'h20);
        @(negedge CLK);
        check("exec_no_valid", {31'h0, TX_VALID}, 32'h0);
        check("exec_busy", {31'h0, BUSY}, 32'h1);
        @(negedge CLK);
        check("send_valid", {31'h0, TX_VALID}, 32'h1);
        @(negedge CLK);
        check("done_valid_low", {31'h0, TX_VALID}, 32'h0);
        check("done_rx_ready", {31'h0, RX_READY}, 32'h1);
        check("count_1", {16'h0, TXN_COUNT}, exp_txn);

        // Test 2: SRA then SRL.
        txn(8'hF9, 8'h02, 8'h03, 8'hFE);
        txn(8'hF9, 8'h02, 8'h02, 8'h3E);

        // Test 3: backpressure on TX, RX bytes offered meanwhile must be held off.
        TX_READY = 1'b0;
        exp_q.push_back(8'h05);
        exp_txn++;
        send_byte(8'h07);
        send_byte(8'h02);
        send_byte(8'h22);
        RX_DATA  = 8'h55;
        RX_VALID = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("bp_valid", {31'h0, TX_VALID}, 32'h1);
            check("bp_data", {24'h0, TX_DATA}, 32'h05);
            check("bp_rx_ready", {31'h0, RX_READY}, 32'h0);
        end
        RX_VALID = 1'b0;
        @(posedge CLK);
        #1;
        TX_READY = 1'b1;
        wait_drain();
        check("bp_not_consumed", {24'h0, DATOA}, 32'h07);

        // Test 4: CLEAR after two operand bytes.
        send_byte(8'h07);
        send_byte(8'h02);
        CLEAR = 1'b1;
        @(posedge CLK);
        #1;
        CLEAR = 1'b0;
        check("clr_rx_ready", {31'h0, RX_READY}, 32'h1);
        check("clr_idle", {31'h0, BUSY}, 32'h0);
        txn(8'h07, 8'h02, 8'h24, 8'h02);

        // CLEAR in SEND with TX_READY high: result dropped, count unchanged.
        send_byte(8'h07);
        send_byte(8'h02);
        send_byte(8'h26);
        @(posedge CLK);
        #1;
        CLEAR = 1'b1;
        @(posedge CLK);
        #1;
        CLEAR = 1'b0;
        check("clr_send_valid", {31'h0, TX_VALID}, 32'h0);
        check("clr_send_count", {16'h0, TXN_COUNT}, exp_txn);
        check("clr_send_ready", {31'h0, RX_READY}, 32'h1);

        // Test 5: reset mid-transaction.
        send_byte(8'h07);
        send_byte(8'h02);
        #2;
        RESET_N = 1'b0;
        #1;
        check("mrst_datoa", {24'h0, DATOA}, 32'h0);
        check("mrst_datob", {24'h0, DATOB}, 32'h0);
        check("mrst_opcode", {26'h0, OPCODE}, 32'h0);
        check("mrst_count", {16'h0, TXN_COUNT}, 32'h0);
        check("mrst_rx_ready", {31'h0, RX_READY}, 32'h1);
        exp_txn = 0;
        @(negedge CLK);
        RESET_N = 1'b1;
        txn(8'h07, 8'h02, 8'h25, 8'h07);

`ifdef ALU_OPCODE_CHECK_EN
        // Test 6: illegal opcode is rejected with an ERROR pulse.
        send_byte(8'h07);
        send_byte(8'h02);
        send_byte(8'h3F);
        check("err_pulse", {31'h0, ERROR}, 32'h1);
        check("err_opcode_kept", {26'h0, OPCODE}, 32'h25);
        @(posedge CLK);
        #1;
        check("err_pulse_end", {31'h0, ERROR}, 32'h0);
        check("err_no_valid", {31'h0, TX_VALID}, 32'h0);
        check("err_rx_ready", {31'h0, RX_READY}, 32'h1);
        check("err_count", {16'h0, TXN_COUNT}, exp_txn);
        txn(8'h07, 8'h02, 8'h27, 8'hF8);
`else
        // Without checking, any byte is loaded and ERROR stays low.
        exp_q.push_back(8'h00);
        exp_txn++;
        send_byte(8'h07);
        send_byte(8'h02);
        send_byte(8'h3F);
        check("noerr_pulse", {31'h0, ERROR}, 32'h0);
        check("noerr_opcode", {26'h0, OPCODE}, 32'h3F);
        wait_drain();
        txn(8'h07, 8'h02, 8'hE0, 8'h09);
        check("upper_bits_dropped", {26'h0, OPCODE}, 32'h20);
        txn(8'h07, 8'h02, 8'h27, 8'hF8);
`endif

        repeat (3) @(negedge CLK);
        check("queue_empty", exp_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
